// File: rtl/m_axi_burst.sv
// AXI4 burst master: turns one command into a single INCR write or read burst,
// bridging a simple write-data source and read-data sink onto the AXI channels.
module m_axi_burst #(
    parameter int ID_WIDTH  = 1,
    parameter int MEM_WIDTH = 32,
    parameter int DWIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 xrst,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [MEM_WIDTH-1:0] cmd_addr,
    input  logic [7:0]           cmd_len,

    input  logic [DWIDTH-1:0]    src_data,
    input  logic                 src_valid,
    output logic                 src_ready,

    output logic [DWIDTH-1:0]    dst_data,
    output logic                 dst_last,
    output logic                 dst_valid,
    input  logic                 dst_ready,

    output logic                 done,
    output logic                 err,

    output logic [ID_WIDTH-1:0]  awid,
    output logic [MEM_WIDTH-1:0] awaddr,
    output logic [7:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic                 awvalid,
    input  logic                 awready,

    output logic [DWIDTH-1:0]    wdata,
    output logic [DWIDTH/8-1:0]  wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,

    input  logic [ID_WIDTH-1:0]  bid,
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,

    output logic [ID_WIDTH-1:0]  arid,
    output logic [MEM_WIDTH-1:0] araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic                 arvalid,
    input  logic                 arready,

    input  logic [ID_WIDTH-1:0]  rid,
    input  logic [DWIDTH-1:0]    rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam int         LSB       = $clog2(DWIDTH / 8);
    localparam logic [2:0] BEAT_SIZE = 3'(LSB);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

    state_t               state, state_nxt;
    logic [MEM_WIDTH-1:0] addr_q;
    logic [7:0]           len_q;
    logic [7:0]           beat_cnt;
    logic                 rd_err_q;
    logic                 cmd_fire, w_fire, b_fire, r_fire;
    logic                 unused_ids;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign w_fire   = wvalid && wready;
    assign b_fire   = bvalid && bready;
    assign r_fire   = rvalid && rready;

    // IDs are fixed at zero, so returned IDs carry no information.
    assign unused_ids = ^{bid, rid};

    assign awid    = '0;
    assign arid    = '0;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign awsize  = BEAT_SIZE;
    assign arsize  = BEAT_SIZE;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awlen   = len_q;
    assign arlen   = len_q;
    assign wstrb   = '1;
    assign wdata   = src_data;
    assign dst_data = rdata;
    assign dst_last = rlast;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)         state_nxt = cmd_write ? WADDR : RADDR;
            WADDR:   if (awready)           state_nxt = WDATA;
            WDATA:   if (w_fire && wlast)   state_nxt = WRESP;
            WRESP:   if (bvalid)            state_nxt = IDLE;
            RADDR:   if (arready)           state_nxt = RDATA;
            RDATA:   if (r_fire && rlast)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        src_ready = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        dst_valid = 1'b0;
        case (state)
            IDLE:  cmd_ready = 1'b1;
            WADDR: awvalid   = 1'b1;
            WDATA: begin
                wvalid    = src_valid;
                src_ready = wready;
                wlast     = (beat_cnt == len_q);
            end
            WRESP: bready  = 1'b1;
            RADDR: arvalid = 1'b1;
            RDATA: begin
                dst_valid = rvalid;
                rready    = dst_ready;
            end
            default: ;
        endcase
    end

    // The last write beat leaves WDATA, so the counter never wraps past len.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            rd_err_q <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (cmd_fire) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                beat_cnt <= '0;
                rd_err_q <= 1'b0;
            end
            if (w_fire) beat_cnt <= wlast ? 8'd0 : beat_cnt + 8'd1;
            if (r_fire && rresp != 2'b00) rd_err_q <= 1'b1;
            if (b_fire) begin
                done <= 1'b1;
                err  <= (bresp != 2'b00);
            end
            if (r_fire && rlast) begin
                done <= 1'b1;
                err  <= rd_err_q || (rresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_m_axi_burst.sv
// Scoreboard bench for m_axi_burst: a slave model answers the AXI channels and
// every beat, address phase and completion is compared against queued expectations.
module tb_m_axi_burst;

    logic        clk = 1'b0;
    logic        xrst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] src_data;
    logic        src_valid, src_ready;
    logic [31:0] dst_data;
    logic        dst_last, dst_valid, dst_ready;
    logic        done, err;
    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    m_axi_burst #(.ID_WIDTH(1), .MEM_WIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .xrst(xrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .dst_data(dst_data), .dst_last(dst_last), .dst_valid(dst_valid), .dst_ready(dst_ready),
        .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          beats;
        int          err_beat;
        logic [31:0] base;
    } rcfg_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_w[$];
    logic [32:0] exp_dst[$];
    logic [39:0] exp_aw[$];
    logic [39:0] exp_ar[$];
    logic        exp_err[$];
    logic [31:0] src_q[$];
    logic [1:0]  bresp_q[$];
    rcfg_t       rcfg_q[$];

    bit    gaps = 1'b0;
    bit    took = 1'b1;
    rcfg_t rc;
    int    r_idx, r_left, outstanding, w_seen;
    logic  b_pend, aw_done, done_due;
    logic  w_hs, b_hs, ar_hs, r_hs, aw_hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd();
        return !gaps || ($urandom_range(0, 3) != 0);
    endfunction

    // Write-data source and read-data sink; valid is held until taken.
    initial begin : source
        src_valid = 1'b0;
        src_data  = '0;
        dst_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (took || !src_valid) src_valid = (src_q.size() > 0) && rnd();
            if (src_q.size() == 0) src_valid = 1'b0;
            else                   src_data  = src_q[0];
            dst_ready = rnd();
            #3;
            took = src_valid && src_ready;
            if (took) void'(src_q.pop_front());
        end
    end

    // Slave model plus monitor: drives on the falling edge, samples 3 ns later.
    initial begin : slave
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        bresp = '0; rresp = '0; rdata = '0; bid = '0; rid = '0;
        {b_pend, aw_done, done_due, w_hs, b_hs, ar_hs, r_hs, aw_hs} = '0;
        r_left = 0; r_idx = 0; outstanding = 0; w_seen = 0;
        forever begin
            @(negedge clk);
            if (!xrst) begin
                {awready, wready, bvalid, arready, rvalid, rlast} = '0;
                {b_pend, aw_done, done_due, w_hs, b_hs, ar_hs, r_hs, aw_hs} = '0;
                r_left = 0;
                outstanding = 0;
                continue;
            end
            if (b_hs) bvalid = 1'b0;
            if (r_hs) rvalid = 1'b0;
            awready = rnd();
            wready  = rnd();
            arready = rnd();
            if (b_pend && !bvalid && rnd()) begin
                bvalid = 1'b1;
                bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
                b_pend = 1'b0;
            end
            if (r_left > 0 && !rvalid && rnd()) begin
                rvalid = 1'b1;
                rdata  = rc.base + 32'(r_idx);
                rresp  = (r_idx == rc.err_beat) ? 2'b10 : 2'b00;
                rlast  = (r_left == 1);
            end
            #3;
            if (!xrst) continue;

            check("done", done, done_due);
            if (done) begin
                if (exp_err.size() > 0) check("err", err, exp_err.pop_front());
                else                    check("done_spurious", done, 1'b0);
                if (outstanding > 0) outstanding--;
            end
            done_due = 1'b0;
            if (cmd_valid && cmd_ready) begin
                check("one_outstanding", outstanding, 0);
                outstanding++;
            end

            if (wvalid) check("w_after_aw", aw_done, 1'b1);
            if (aw_done) check("src_ready_pass", src_ready, wready);
            w_hs = wvalid && wready;
            if (w_hs) begin
                w_seen++;
                check("wstrb", wstrb, 4'hf);
                if (exp_w.size() > 0) check("w_beat", {wlast, wdata}, exp_w.pop_front());
                else                  check("w_extra", wvalid, 1'b0);
                if (wlast) begin
                    aw_done = 1'b0;
                    b_pend  = 1'b1;
                end
            end
            aw_hs = awvalid && awready;
            if (aw_hs) begin
                if (exp_aw.size() > 0) check("aw", {awaddr, awlen}, exp_aw.pop_front());
                else                   check("aw_extra", awvalid, 1'b0);
                check("awsize", awsize, 3'd2);
                check("awburst", awburst, 2'b01);
                check("awid", awid, 1'b0);
                aw_done = 1'b1;
            end
            b_hs = bvalid && bready;
            if (b_hs) done_due = 1'b1;

            if (r_left > 0) check("rready_pass", rready, dst_ready);
            r_hs = rvalid && rready;
            if (r_hs) begin
                r_idx++;
                r_left--;
                if (rlast) begin
                    r_left   = 0;
                    done_due = 1'b1;
                end
            end
            if (dst_valid && dst_ready) begin
                if (exp_dst.size() > 0) check("dst_beat", {dst_last, dst_data}, exp_dst.pop_front());
                else                    check("dst_extra", dst_valid, 1'b0);
            end
            ar_hs = arvalid && arready;
            if (ar_hs) begin
                if (exp_ar.size() > 0) check("ar", {araddr, arlen}, exp_ar.pop_front());
                else                   check("ar_extra", arvalid, 1'b0);
                check("arsize", arsize, 3'd2);
                check("arburst", arburst, 2'b01);
                check("arid", arid, 1'b0);
                if (rcfg_q.size() > 0) begin
                    rc     = rcfg_q.pop_front();
                    r_left = rc.beats;
                    r_idx  = 0;
                end
            end
        end
    end

    task automatic push_write(input logic [31:0] addr, input int len, input logic [31:0] base,
                              input logic [1:0] resp);
        exp_aw.push_back({addr, 8'(len)});
        for (int i = 0; i <= len; i++) begin
            exp_w.push_back({i == len, base + 32'(i)});
            src_q.push_back(base + 32'(i));
        end
        bresp_q.push_back(resp);
        exp_err.push_back(resp != 2'b00);
    endtask

    task automatic push_read(input logic [31:0] addr, input int len, input int beats,
                             input int err_beat, input logic [31:0] base);
        rcfg_t c;
        c.beats = beats; c.err_beat = err_beat; c.base = base;
        exp_ar.push_back({addr, 8'(len)});
        rcfg_q.push_back(c);
        for (int i = 0; i < beats; i++) exp_dst.push_back({i == beats - 1, base + 32'(i)});
        exp_err.push_back(err_beat >= 0 && err_beat < beats);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        for (int n = 0; n < 3000; n++) begin
            #4;
            if (cmd_ready) break;
            @(negedge clk);
        end
        check("cmd_accept", cmd_ready, 1'b1);
    endtask

    task automatic drop_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 5000 && exp_err.size() > 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        #4;
        check("all_done", exp_err.size(), 0);
        check("w_drained", exp_w.size(), 0);
        check("dst_drained", exp_dst.size(), 0);
    endtask

    task automatic run_write(input logic [31:0] addr, input int len, input logic [31:0] base,
                             input logic [1:0] resp);
        push_write(addr, len, base, resp);
        issue(1'b1, addr, len);
        drop_cmd();
        wait_done();
    endtask

    task automatic run_read(input logic [31:0] addr, input int len, input int beats,
                            input int err_beat, input logic [31:0] base);
        push_read(addr, len, beats, err_beat, base);
        issue(1'b0, addr, len);
        drop_cmd();
        wait_done();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          w0, len_r, eb;
        logic [31:0] addr_r;
        xrst = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        #12;
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_src_ready", src_ready, 1'b0);
        check("rst_dst_valid", dst_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        #2 xrst = 1'b1;
        #1 check("cmd_ready_after_rst", cmd_ready, 1'b1);

        run_write(32'h100, 3, 32'd1, 2'b00);
        run_read(32'h40, 0, 1, -1, 32'hC0DE0000);
        run_write(32'h80, 0, 32'h77, 2'b00);

        gaps = 1'b1;
        run_write(32'h1000, 255, 32'h1000, 2'b00);
        gaps = 1'b0;

        run_read(32'h200, 2, 3, 1, 32'hA000);
        run_read(32'h300, 1, 2, -1, 32'hB000);
        run_read(32'h340, 1, 2, 1, 32'hB100);
        run_write(32'h400, 1, 32'h40, 2'b10);
        run_read(32'h380, 3, 2, -1, 32'hD000);

        push_write(32'h800, 1, 32'h800, 2'b00);
        push_read(32'h900, 1, 2, -1, 32'h900);
        issue(1'b1, 32'h800, 1);
        issue(1'b0, 32'h900, 1);
        drop_cmd();
        wait_done();

        gaps = 1'b1;
        for (int k = 0; k < 6; k++) begin
            len_r  = int'($urandom_range(0, 15));
            addr_r = 32'($urandom_range(0, 1023)) << 2;
            if (k % 2 == 0) run_write(addr_r, len_r, 32'(k) << 8, 2'b00);
            else begin
                eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len_r)) : -1;
                run_read(addr_r, len_r, len_r + 1, eb, 32'(k) << 12);
            end
        end
        gaps = 1'b0;

        push_write(32'h500, 7, 32'h50, 2'b00);
        w0 = w_seen;
        issue(1'b1, 32'h500, 7);
        drop_cmd();
        for (int n = 0; n < 500 && w_seen == w0; n++) @(negedge clk);
        check("beat1_seen", w_seen - w0, 1);
        #1 xrst = 1'b0;
        #1;
        check("mid_rst_wvalid", wvalid, 1'b0);
        check("mid_rst_awvalid", awvalid, 1'b0);
        check("mid_rst_src_ready", src_ready, 1'b0);
        check("mid_rst_bready", bready, 1'b0);
        check("mid_rst_done", done, 1'b0);
        exp_w.delete(); exp_aw.delete(); exp_err.delete(); src_q.delete(); bresp_q.delete();
        exp_ar.delete(); exp_dst.delete(); rcfg_q.delete();
        repeat (2) @(negedge clk);
        #2 xrst = 1'b1;
        #1 check("cmd_ready_after_mid_rst", cmd_ready, 1'b1);
        run_write(32'h600, 3, 32'hA0, 2'b00);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
